transmitter: RTL and testbench
==============================

TRANSMITTER -- requirements
Module: transmitter

Interface
REQ-001 The module SHALL have one parameter: CLKS_PER_BIT, default 2500, clock cycles per serial bit (legal range 2..4095).
REQ-002 The module SHALL have the port clk  input  1  single system clock; all logic is on its rising edge.
REQ-003 The module SHALL have the port rst  input  1  reset, synchronous and active-high.
REQ-004 The module SHALL have the port data_in  input  8  byte to send, sampled when send && ready.
REQ-005 The module SHALL have the port send  input  1  request strobe; a byte is accepted on a rising edge where send && ready.
REQ-006 The module SHALL have the port ready  output  1  high when the one-entry holding buffer is empty.
REQ-007 The module SHALL have the port busy  output  1  high while the FSM is not in IDLE.
REQ-008 The module SHALL have the port tx_done  output  1  one-cycle pulse after each frame's stop bit completes.
REQ-009 The module SHALL have the port Tx  output  1  registered serial line, idle high.

Function
REQ-010 The frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), each exactly CLKS_PER_BIT cycles, 10*CLKS_PER_BIT cycles in total.
REQ-011 The FSM states SHALL be IDLE, START, DATA, STOP.
REQ-012 An accepted byte SHALL always enter the holding buffer; ready SHALL deassert on the edge where the byte is accepted.
REQ-013 In IDLE with the buffer full, the FSM SHALL move the buffer into the shift register, clear the buffer, and enter START; Tx SHALL fall on that same edge, one cycle after the acceptance edge.
REQ-014 A baud counter SHALL count 0..CLKS_PER_BIT-1; state/bit advances occur only on the cycle the counter equals CLKS_PER_BIT-1, and the counter then wraps to 0.
REQ-015 On advance: START goes to DATA with bit index 0; DATA increments a 3-bit index and shifts right; DATA at index 7 goes to STOP; Tx carries the current shift-register LSB throughout DATA.
REQ-016 At the end of STOP with the buffer full, the FSM SHALL go directly to START (no idle gap, back-to-back frames).
REQ-017 At the end of STOP with the buffer empty, the FSM SHALL go to IDLE; a byte accepted on that same edge is handled via IDLE (exactly one idle-high cycle).
REQ-018 tx_done SHALL be high for exactly the one cycle following each stop-bit end edge, including in back-to-back operation.
REQ-019 send while ready=0 SHALL be ignored; data_in SHALL NOT be sampled and no state SHALL change.
REQ-020 A new byte SHALL be accepted while a frame is in progress (buffer empty) without disturbing the current frame.
REQ-021 The bit index SHALL never wrap silently; index 7 is the only exit from DATA.

Reset
REQ-022 On rst=1 the outputs SHALL be Tx=1, ready=1, busy=0, tx_done=0.
REQ-023 On rst=1 the internal state SHALL be: FSM=IDLE, buffer empty, baud counter 0, bit index 0, shift register 0.
REQ-024 rst SHALL take priority over send and over any frame in progress; a partial frame and any buffered byte are discarded and Tx is high on the cycle after rst is sampled.

Structure
REQ-025 A shared package uart_pkg SHALL hold the CLKS_PER_BIT default, DATA_BITS=8, the state enum, and the baud-counter width (12 bits), shared with receiver-side logic.
REQ-026 One sub-module, baud_counter (count, wrap, terminal-count flag, synchronous clear), is natural; the FSM, holding buffer and shift register stay in transmitter.

Verification
REQ-027 The bench SHALL cover single byte: rst released, send 0xA5 (CLKS_PER_BIT=2500) -> Tx=0,1,0,1,0,0,1,0,1,1, each held 2500 cycles; tx_done pulses once at cycle 25001 after acceptance; busy falls then.
REQ-028 The bench SHALL cover back-to-back: send 0x00, then send 0xFF while the first frame is in DATA -> ready low until the second byte moves to the shift register; the second start bit begins immediately after the first stop bit; 20*CLKS_PER_BIT cycles total; two tx_done pulses.
REQ-029 The bench SHALL cover buffer full: with a frame active and the buffer holding 0x3C, send 0x99 -> ignored; the serial output carries 0x3C next, and 0x99 never appears.
REQ-030 The bench SHALL cover boundary: send 0x55 on the exact stop-end edge with the buffer empty -> exactly one idle-high cycle, then a 0x55 frame.
REQ-031 The bench SHALL cover mid-frame reset: rst=1 for 1 cycle during data bit 3 -> next cycle Tx=1, busy=0, ready=1, and no tx_done ever for that frame.
REQ-032 The bench SHALL cover the loopback case: transmitter Tx wired to the team receiver, random 256 bytes -> every byte is received with data_valid, and the received data equals the sent data in order.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and receiver-side logic:
// frame geometry, baud-counter width and the serial FSM state encoding.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 32'd2500;
    localparam int unsigned DATA_BITS            = 32'd8;
    localparam int unsigned BAUD_W               = 32'd12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Terminal count value of the baud counter for a given bit period.
    function automatic logic [BAUD_W-1:0] baud_last(input int unsigned clks);
        baud_last = BAUD_W'(clks - 32'd1);
    endfunction

endpackage

// File: rtl/transmitter_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, wraps, and flags the last
// cycle of each bit period. A synchronous clear holds it at zero.
module baud_counter
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tc
);

    localparam logic [BAUD_W-1:0] LAST = baud_last(CLKS_PER_BIT);

    logic [BAUD_W-1:0] count_q;
    logic [BAUD_W-1:0] count_d;

    // Next count: clear wins, otherwise wrap at the terminal count.
    always_comb begin
        count_d = count_q;
        tc      = (count_q == LAST);
        if (clear) begin
            count_d = BAUD_W'(0);
        end else if (tc) begin
            count_d = BAUD_W'(0);
        end else begin
            count_d = count_q + BAUD_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= BAUD_W'(0);
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/transmitter.sv
// 8N1 UART transmitter with a one-entry holding buffer in front of the
// shift register, allowing back-to-back frames with no idle gap.
module transmitter
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 send,
    output logic                 ready,
    output logic                 busy,
    output logic                 tx_done,
    output logic                 Tx
);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] buf_q, buf_d;
    logic                 buf_full_q, buf_full_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 tx_q, tx_d;
    logic                 tx_done_q, tx_done_d;
    logic                 baud_tc;
    logic                 accept;

    baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(state_q == IDLE),
        .tc   (baud_tc)
    );

    // Holding buffer, FSM next state, shift register and next serial level.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        tx_done_d  = 1'b0;
        accept     = send && !buf_full_q;

        // A load only happens with the buffer full, so it never coincides with accept.
        if (accept) begin
            buf_d      = data_in;
            buf_full_d = 1'b1;
        end else begin
            buf_d      = buf_q;
            buf_full_d = buf_full_q;
        end

        case (state_q)
            IDLE: begin
                if (buf_full_q) begin
                    state_d    = START;
                    shift_d    = buf_q;
                    buf_full_d = 1'b0;
                    bit_idx_d  = 3'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (baud_tc) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (baud_tc) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
                    end
                end else begin
                    state_d = DATA;
                end
            end
            STOP: begin
                if (baud_tc) begin
                    tx_done_d = 1'b1;
                    if (buf_full_q) begin
                        state_d    = START;
                        shift_d    = buf_q;
                        buf_full_d = 1'b0;
                        bit_idx_d  = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            buf_q      <= {DATA_BITS{1'b0}};
            buf_full_q <= 1'b0;
            shift_q    <= {DATA_BITS{1'b0}};
            bit_idx_q  <= 3'd0;
            tx_q       <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign ready   = !buf_full_q;
    assign busy    = (state_q != IDLE);
    assign tx_done = tx_done_q;
    assign Tx      = tx_q;

endmodule

// File: tb/tb_transmitter.sv
// Directed and randomized bench for the UART transmitter, with a sampling
// serial receiver model for the loopback stage.
module tb_transmitter;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       send;
    logic [7:0] data_in;
    logic       ready;
    logic       busy;
    logic       tx_done;
    logic       tx;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    logic       rx_en = 1'b0;
    logic       prev_tx = 1'b1;
    logic       rx_active = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh = 8'h00;
    int         rx_err = 0;
    logic [7:0] rx_q[$];
    logic [7:0] sent_q[$];

    transmitter #(.CLKS_PER_BIT(C)) dut (
        .clk    (clk),
        .rst    (rst),
        .data_in(data_in),
        .send   (send),
        .ready  (ready),
        .busy   (busy),
        .tx_done(tx_done),
        .Tx     (tx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // Mid-bit sampling receiver: bit k is sampled C/2 cycles into its period.
    always @(negedge clk) begin
        if (rx_active) begin
            rx_cnt <= rx_cnt + 1;
            if ((rx_cnt % C) == (C / 2)) begin
                if (rx_cnt / C == 0) begin
                    if (tx !== 1'b0) rx_err <= rx_err + 1;
                end else if (rx_cnt / C <= 8) begin
                    rx_sh <= {tx, rx_sh[7:1]};
                end else begin
                    if (tx === 1'b1) rx_q.push_back(rx_sh);
                    else rx_err <= rx_err + 1;
                    rx_active <= 1'b0;
                end
            end
        end else if (rx_en && prev_tx === 1'b1 && tx === 1'b0) begin
            rx_active <= 1'b1;
            rx_cnt    <= 1;
        end
        prev_tx <= tx;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_done(input int exp);
        @(posedge clk);
        #1;
        chk("tx_done_count", done_cnt, exp);
    endtask

    // Waits (bounded) for ready, then presents one byte for one accepting edge.
    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 20 * C; i++) begin
            @(negedge clk);
            if (ready === 1'b1) break;
        end
        chk("ready_before_send", ready, 1);
        data_in = b;
        send    = 1'b1;
        @(posedge clk);
        #1;
        send    = 1'b0;
        data_in = 8'($urandom);
        chk("ready_after_accept", ready, 0);
    endtask

    // Called just after the edge on which a start bit begins; checks the whole
    // frame cycle by cycle and optionally injects sends or a reset mid-frame.
    task automatic check_bits(input logic [7:0] b, input logic done_first,
                              input int at1, input logic [7:0] d1,
                              input int at2, input logic [7:0] d2,
                              input int rst_at);
        logic [9:0] fr;
        logic       exp_ready;
        fr        = {1'b1, b, 1'b0};
        exp_ready = 1'b1;
        for (int n = 0; n < 10 * C; n++) begin
            @(negedge clk);
            chk("frame_tx", tx, fr[n / C]);
            chk("frame_busy", busy, 1);
            chk("frame_ready", ready, exp_ready);
            chk("frame_tx_done", tx_done, (n == 0) ? done_first : 1'b0);
            send = 1'b0;
            if (n == at1) begin
                data_in = d1; send = 1'b1; exp_ready = 1'b0;
            end
            if (n == at2) begin
                data_in = d2; send = 1'b1; exp_ready = 1'b0;
            end
            if (n == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_tx", tx, 1);
                chk("rst_busy", busy, 0);
                chk("rst_ready", ready, 1);
                chk("rst_tx_done", tx_done, 0);
                for (int k = 0; k < 12 * C; k++) begin
                    @(negedge clk);
                    chk("post_rst_tx", tx, 1);
                    chk("post_rst_tx_done", tx_done, 0);
                end
                return;
            end
        end
    endtask

    initial begin
        logic [7:0] b;
        int         n_rx;
        rst     = 1'b1;
        send    = 1'b0;
        data_in = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_ready", ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_tx_done", tx_done, 0);
        send    = 1'b1;
        data_in = 8'h77;
        @(negedge clk);
        chk("reset_over_send_ready", ready, 1);
        chk("reset_over_send_busy", busy, 0);
        rst  = 1'b0;
        send = 1'b0;
        @(posedge clk);
        #1;

        // Single byte
        send_byte(8'hA5);
        @(posedge clk);
        check_bits(8'hA5, 1'b0, -1, 8'h00, -1, 8'h00, -1);
        @(posedge clk);
        @(negedge clk);
        chk("single_tx_done", tx_done, 1);
        chk("single_busy", busy, 0);
        chk("single_tx", tx, 1);
        chk("single_ready", ready, 1);
        @(negedge clk);
        chk("single_tx_done_width", tx_done, 0);
        chk_done(1);

        // Back-to-back: second byte arrives during the first frame's DATA
        send_byte(8'h00);
        @(posedge clk);
        check_bits(8'h00, 1'b0, 3 * C, 8'hFF, -1, 8'h00, -1);
        @(posedge clk);
        check_bits(8'hFF, 1'b1, -1, 8'h00, -1, 8'h00, -1);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_tx_done", tx_done, 1);
        chk("b2b_busy", busy, 0);
        chk_done(3);

        // Buffer full: 0x99 offered while 0x3C is waiting must be dropped
        send_byte(8'h12);
        @(posedge clk);
        check_bits(8'h12, 1'b0, C + 2, 8'h3C, 5 * C, 8'h99, -1);
        @(posedge clk);
        check_bits(8'h3C, 1'b1, -1, 8'h00, -1, 8'h00, -1);
        @(posedge clk);
        @(negedge clk);
        chk("full_tx_done", tx_done, 1);
        chk("full_busy", busy, 0);
        for (int i = 0; i < 3 * C; i++) begin
            @(negedge clk);
            chk("full_idle_tx", tx, 1);
            chk("full_idle_busy", busy, 0);
            chk("full_idle_ready", ready, 1);
        end
        chk_done(5);

        // Boundary: accept on the exact stop-end edge with the buffer empty
        send_byte(8'h0F);
        @(posedge clk);
        check_bits(8'h0F, 1'b0, -1, 8'h00, -1, 8'h00, -1);
        data_in = 8'h55;
        send    = 1'b1;
        @(posedge clk);
        #1;
        send = 1'b0;
        @(negedge clk);
        chk("edge_idle_tx", tx, 1);
        chk("edge_tx_done", tx_done, 1);
        chk("edge_busy", busy, 0);
        chk("edge_ready", ready, 0);
        @(posedge clk);
        check_bits(8'h55, 1'b0, -1, 8'h00, -1, 8'h00, -1);
        @(posedge clk);
        @(negedge clk);
        chk("edge_frame_tx_done", tx_done, 1);
        chk("edge_frame_busy", busy, 0);
        chk_done(7);

        // Reset during data bit 3
        send_byte(8'hC3);
        @(posedge clk);
        check_bits(8'hC3, 1'b0, -1, 8'h00, -1, 8'h00, 4 * C + 1);
        chk_done(7);

        // Loopback of random bytes through the receiver model
        rx_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom);
            sent_q.push_back(b);
            send_byte(b);
        end
        for (int i = 0; i < 40 * C; i++) begin
            @(negedge clk);
            if (rx_q.size() == 256) break;
        end
        n_rx = rx_q.size();
        chk("loopback_count", n_rx, 256);
        chk("loopback_frame_errors", rx_err, 0);
        for (int i = 0; i < 256; i++) begin
            chk("loopback_data", (i < n_rx) ? {24'h0, rx_q[i]} : 32'hFFFF_FFFF, {24'h0, sent_q[i]});
        end
        repeat (2 * C) @(posedge clk);
        chk_done(7 + 256);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
